// File: rtl/extra_hdr_noc_ctrl_to_data_if.sv
// Handshake bundle between the ctrl-NoC egress (narrow flits in) and the
// data-NoC side (one wide header flit out).
//   src_noc_ctd_val/data, noc_ctd_src_rdy : narrow flit stream into the adapter
//   noc_ctd_dst_val/data, dst_noc_ctd_rdy : wide header flit out of the adapter
//   hdr_len_err                           : routing-flit msg_len mismatch pulse
// slave  = the adapter itself, master = whatever drives/consumes it.
interface extra_hdr_noc_ctrl_to_data_if #(
  parameter int CTRL_W = 64,
  parameter int NOC_W  = 512
);
  logic              src_noc_ctd_val;
  logic [CTRL_W-1:0] src_noc_ctd_data;
  logic              noc_ctd_src_rdy;
  logic              noc_ctd_dst_val;
  logic [NOC_W-1:0]  noc_ctd_dst_data;
  logic              dst_noc_ctd_rdy;
  logic              hdr_len_err;

  modport slave (
    input  src_noc_ctd_val, src_noc_ctd_data, dst_noc_ctd_rdy,
    output noc_ctd_src_rdy, noc_ctd_dst_val, noc_ctd_dst_data, hdr_len_err
  );

  modport master (
    output src_noc_ctd_val, src_noc_ctd_data, dst_noc_ctd_rdy,
    input  noc_ctd_src_rdy, noc_ctd_dst_val, noc_ctd_dst_data, hdr_len_err
  );
endinterface

// File: rtl/extra_hdr_noc_ctrl_to_data.sv
// Reassembles a ctrl-NoC message (routing flit, misc flit, EXTRA_FLITS extra
// header flits) into one wide data-NoC header flit with msg_len forced to 0
// and EXTRA_W bits of extra header attached below the base header.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : extra_hdr_noc_ctrl_to_data_if.slave (narrow in, wide out,
//                hdr_len_err pulse)
// Flit layout (CTRL_NOC1_DATA_W bits, LSB numbering):
//   routing flit : msg_len at [29:22]
//   misc flit    : {src_chip_id, src_x, src_y, src_fbits} at [63:30]
// Wide flit layout (NOC_DATA_WIDTH bits):
//   [NOC-1 -: CTRL]            routing flit, msg_len zeroed
//   [NOC-CTRL-1 -: 34]         core src_* fields from misc flit
//   [NOC-BASE-1 -: EXTRA_W]    extra header, first extra flit most significant
//   all other bits             0
//
// state   | meaning
// HDR1    | waiting for routing flit
// HDR2    | waiting for misc flit
// EXTRAS  | collecting extra-header flits, counter = flits still expected
// OUT     | wide flit valid, waiting for downstream ready
module extra_hdr_noc_ctrl_to_data #(
  parameter int EXTRA_W          = 96,
  parameter int CTRL_NOC1_DATA_W = 64,
  parameter int NOC_DATA_WIDTH   = 512,
  parameter int BASE_FLIT_W      = 192
) (
  input  logic clk,
  input  logic rst_n,
  extra_hdr_noc_ctrl_to_data_if.slave bus
);

  localparam int EXTRA_FLITS = (EXTRA_W + CTRL_NOC1_DATA_W - 1) / CTRL_NOC1_DATA_W;
  localparam int SAVE_W      = EXTRA_FLITS * CTRL_NOC1_DATA_W;
  localparam int CNT_W       = (EXTRA_FLITS > 1) ? $clog2(EXTRA_FLITS + 1) : 1;
  localparam int MSG_LEN_LSB = 22;
  localparam int MSG_LEN_W   = 8;
  localparam int SRC_LSB     = 30;
  localparam int SRC_W       = 34;
  localparam logic [MSG_LEN_W-1:0] EXP_LEN = MSG_LEN_W'(1 + EXTRA_FLITS);

  typedef enum logic [1:0] {S_HDR1, S_HDR2, S_EXTRAS, S_OUT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [NOC_DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                      r_len_err, w_len_err_nxt;
  logic                      w_src_rdy, w_dst_val, w_acc, w_ext_en, w_len_bad;
  logic [SAVE_W-1:0]         w_ext_full;

  // Routing flit placed at the top, msg_len cleared, everything below zeroed.
  function automatic logic [NOC_DATA_WIDTH-1:0] f_route(input logic [CTRL_NOC1_DATA_W-1:0] flit);
    logic [CTRL_NOC1_DATA_W-1:0] v;
    v = flit;
    v[MSG_LEN_LSB +: MSG_LEN_W] = '0;
    f_route = '0;
    f_route[NOC_DATA_WIDTH-1 -: CTRL_NOC1_DATA_W] = v;
  endfunction

  assign w_len_bad = (bus.src_noc_ctd_data[MSG_LEN_LSB +: MSG_LEN_W] != EXP_LEN);

  // Only the flits before the last one need storing; the last one is used
  // straight off the input, so the shift register is one flit narrower.
  if (EXTRA_FLITS > 1) begin : g_multi
    logic [SAVE_W-CTRL_NOC1_DATA_W-1:0] r_ext;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_ext <= '0;
      else if (w_ext_en) r_ext <= w_ext_full[SAVE_W-CTRL_NOC1_DATA_W-1:0];
    end
    assign w_ext_full = {r_ext, bus.src_noc_ctd_data};
  end else begin : g_single
    assign w_ext_full = bus.src_noc_ctd_data;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_len_err_nxt = 1'b0;
    w_src_rdy     = 1'b0;
    w_dst_val     = 1'b0;
    w_acc         = 1'b0;
    w_ext_en      = 1'b0;
    case (r_state)
      S_HDR1: begin
        w_src_rdy = rst_n;
        w_acc     = bus.src_noc_ctd_val & w_src_rdy;
        if (w_acc) begin
          w_data_nxt    = f_route(bus.src_noc_ctd_data);
          w_len_err_nxt = w_len_bad;
          w_state_nxt   = S_HDR2;
        end
      end
      S_HDR2: begin
        w_src_rdy = rst_n;
        w_acc     = bus.src_noc_ctd_val & w_src_rdy;
        if (w_acc) begin
          w_data_nxt[NOC_DATA_WIDTH-CTRL_NOC1_DATA_W-1 -: SRC_W] =
            bus.src_noc_ctd_data[SRC_LSB +: SRC_W];
          w_cnt_nxt   = CNT_W'(EXTRA_FLITS);
          w_state_nxt = S_EXTRAS;
        end
      end
      S_EXTRAS: begin
        w_src_rdy = rst_n;
        w_acc     = bus.src_noc_ctd_val & w_src_rdy;
        w_ext_en  = w_acc;
        if (w_acc) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // Padding sits in the LS bits of the last flit and is dropped here.
            w_data_nxt[NOC_DATA_WIDTH-BASE_FLIT_W-1 -: EXTRA_W] = w_ext_full[SAVE_W-1 -: EXTRA_W];
            w_state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        w_dst_val = 1'b1;
        w_src_rdy = rst_n & bus.dst_noc_ctd_rdy;
        w_acc     = bus.src_noc_ctd_val & w_src_rdy;
        if (w_acc) begin
          // Output handshake and next routing flit in the same cycle.
          w_data_nxt    = f_route(bus.src_noc_ctd_data);
          w_len_err_nxt = w_len_bad;
          w_state_nxt   = S_HDR2;
        end else if (bus.dst_noc_ctd_rdy) begin
          w_state_nxt = S_HDR1;
        end
      end
      default: w_state_nxt = S_HDR1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HDR1;
      r_cnt     <= '0;
      r_data    <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_len_err <= w_len_err_nxt;
    end
  end

  assign bus.noc_ctd_src_rdy  = w_src_rdy;
  assign bus.noc_ctd_dst_val  = w_dst_val;
  assign bus.noc_ctd_dst_data = r_data;
  assign bus.hdr_len_err      = r_len_err;

endmodule

// File: tb/tb_extra_hdr_noc_ctrl_to_data.sv
module tb_extra_hdr_noc_ctrl_to_data;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  extra_hdr_noc_ctrl_to_data_if #(.CTRL_W(64), .NOC_W(512)) bus_a();
  extra_hdr_noc_ctrl_to_data_if #(.CTRL_W(64), .NOC_W(512)) bus_b();

  extra_hdr_noc_ctrl_to_data #(.EXTRA_W(96)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  extra_hdr_noc_ctrl_to_data #(.EXTRA_W(64)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
  int err_exp_a = 0, err_seen_a = 0, err_exp_b = 0, err_seen_b = 0;
  logic [511:0] q_a[$];
  logic [511:0] q_b[$];
  logic [511:0] pop_a, pop_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the wide header as the message's fields dictate.
  function automatic logic [511:0] exp_flit(input logic [63:0] r, input logic [63:0] m,
                                            input logic [127:0] ext, input int ew);
    logic [511:0] e;
    e = '0;
    e[511 -: 64] = r;
    for (int i = 0; i < 8; i++) e[448 + 22 + i] = 1'b0;
    e[447 -: 34] = m[63:30];
    for (int i = 0; i < ew; i++) e[319 - i] = ext[127 - i];
    return e;
  endfunction

  initial begin
    bus_a.dst_noc_ctd_rdy = 1'b1;
    bus_b.dst_noc_ctd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: begin bus_a.dst_noc_ctd_rdy = 1'b1; bus_b.dst_noc_ctd_rdy = 1'b1; end
        1: begin bus_a.dst_noc_ctd_rdy = 1'($urandom_range(1)); bus_b.dst_noc_ctd_rdy = 1'($urandom_range(1)); end
        default: begin bus_a.dst_noc_ctd_rdy = 1'b0; bus_b.dst_noc_ctd_rdy = 1'b0; end
      endcase
    end
  end

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.hdr_len_err) err_seen_a++;
      if (bus_a.noc_ctd_dst_val && bus_a.dst_noc_ctd_rdy) begin
        if (q_a.size() == 0) chk(1'b0, "a_unexpected_flit", bus_a.noc_ctd_dst_data, '0);
        else begin
          pop_a = q_a.pop_front();
          chk(bus_a.noc_ctd_dst_data === pop_a, "a_flit", bus_a.noc_ctd_dst_data, pop_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.hdr_len_err) err_seen_b++;
      if (bus_b.noc_ctd_dst_val && bus_b.dst_noc_ctd_rdy) begin
        if (q_b.size() == 0) chk(1'b0, "b_unexpected_flit", bus_b.noc_ctd_dst_data, '0);
        else begin
          pop_b = q_b.pop_front();
          chk(bus_b.noc_ctd_dst_data === pop_b, "b_flit", bus_b.noc_ctd_dst_data, pop_b);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the flit is accepted.
  task automatic drive(input bit sel, input logic [63:0] f, input bit bub, output int acc_cyc);
    int t;
    bit rdy;
    if (bub) while ($urandom_range(1) == 0) begin @(posedge clk); #1; end
    if (sel) begin bus_b.src_noc_ctd_val = 1'b1; bus_b.src_noc_ctd_data = f; end
    else     begin bus_a.src_noc_ctd_val = 1'b1; bus_a.src_noc_ctd_data = f; end
    t = 0;
    forever begin
      @(negedge clk);
      rdy = sel ? bus_b.noc_ctd_src_rdy : bus_a.noc_ctd_src_rdy;
      if (rdy) break;
      t++;
      if (t > 500) begin chk(1'b0, "src_rdy_timeout", 512'(t), 512'd500); break; end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (sel) bus_b.src_noc_ctd_val = 1'b0;
    else     bus_a.src_noc_ctd_val = 1'b0;
  endtask

  task automatic send_msg(input bit sel, input logic [63:0] r, input logic [63:0] m,
                          input logic [63:0] e0, input logic [63:0] e1, input bit bub,
                          output int first_cyc, output int last_cyc);
    int c;
    drive(sel, r, bub, first_cyc);
    drive(sel, m, bub, c);
    drive(sel, e0, bub, last_cyc);
    if (!sel) drive(sel, e1, bub, last_cyc);
    if (sel) begin
      q_b.push_back(exp_flit(r, m, {e0, 64'h0}, 64));
      if (r[29:22] != 8'd2) err_exp_b++;
    end else begin
      q_a.push_back(exp_flit(r, m, {e0, e1}, 96));
      if (r[29:22] != 8'd3) err_exp_a++;
    end
  endtask

  task automatic send_rand(input bit sel, input bit bub);
    logic [63:0] r, m, e0, e1;
    int f, l;
    r = {$urandom, $urandom};
    r[29:22] = ($urandom_range(9) == 0) ? 8'd5 : (sel ? 8'd2 : 8'd3);
    m = {$urandom, $urandom};
    e0 = {$urandom, $urandom};
    e1 = {$urandom, $urandom};
    send_msg(sel, r, m, e0, e1, bub, f, l);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r, m, e0, e1;
    logic [511:0] snap;
    int f, l, c;
    bit ok;

    bus_a.src_noc_ctd_val = 1'b0; bus_a.src_noc_ctd_data = '0;
    bus_b.src_noc_ctd_val = 1'b0; bus_b.src_noc_ctd_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus_a.noc_ctd_src_rdy == 1'b0, "rst_src_rdy", 512'(bus_a.noc_ctd_src_rdy), '0);
    chk(bus_a.noc_ctd_dst_val == 1'b0, "rst_dst_val", 512'(bus_a.noc_ctd_dst_val), '0);
    chk(bus_a.noc_ctd_dst_data === '0, "rst_data", bus_a.noc_ctd_dst_data, '0);
    chk(bus_a.hdr_len_err == 1'b0, "rst_len_err", 512'(bus_a.hdr_len_err), '0);
    chk(bus_b.noc_ctd_src_rdy == 1'b0, "rst_b_src_rdy", 512'(bus_b.noc_ctd_src_rdy), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(bus_a.noc_ctd_src_rdy == 1'b1, "post_rst_src_rdy", 512'(bus_a.noc_ctd_src_rdy), 512'd1);
    @(posedge clk); #1;

    // Directed message, no stalls.
    r = 64'h0123_4567_00C0_0000; r[29:22] = 8'd3;
    m = 64'hFEDC_BA98_7654_3210;
    e0 = 64'hAAAA_BBBB_CCCC_DDDD;
    e1 = 64'h1111_2222_DEAD_BEEF;
    send_msg(1'b0, r, m, e0, e1, 1'b0, f, l);
    chk(l - f == 3, "a_input_cycles", 512'(l - f), 512'd3);
    chk(bus_a.noc_ctd_dst_val == 1'b1, "a_latency", 512'(bus_a.noc_ctd_dst_val), 512'd1);
    chk(bus_a.noc_ctd_dst_data[319 -: 96] == 96'hAAAABBBBCCCCDDDD11112222, "a_extra_field",
        512'(bus_a.noc_ctd_dst_data[319 -: 96]), 512'(96'hAAAABBBBCCCCDDDD11112222));
    chk(bus_a.noc_ctd_dst_data[477:470] == 8'd0, "a_msg_len_zero",
        512'(bus_a.noc_ctd_dst_data[477:470]), '0);
    chk(bus_a.noc_ctd_dst_data[447 -: 34] == m[63:30], "a_src_fields",
        512'(bus_a.noc_ctd_dst_data[447 -: 34]), 512'(m[63:30]));
    @(posedge clk); #1;

    // Output backpressure, then back-to-back handshake.
    rdy_mode = 2;
    r = {$urandom, $urandom}; r[29:22] = 8'd3;
    send_msg(1'b0, r, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, f, l);
    @(negedge clk);
    snap = bus_a.noc_ctd_dst_data;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_a.noc_ctd_dst_val || bus_a.noc_ctd_src_rdy || bus_a.noc_ctd_dst_data !== snap) ok = 1'b0;
    end
    chk(ok, "a_hold_stable", bus_a.noc_ctd_dst_data, snap);
    @(posedge clk); #1;
    rdy_mode = 0;
    r = {$urandom, $urandom}; r[29:22] = 8'd3;
    m = {$urandom, $urandom}; e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
    bus_a.src_noc_ctd_val = 1'b1; bus_a.src_noc_ctd_data = r;
    @(negedge clk);
    chk(bus_a.noc_ctd_src_rdy && bus_a.noc_ctd_dst_val, "a_b2b_handshake",
        512'({bus_a.noc_ctd_src_rdy, bus_a.noc_ctd_dst_val}), 512'd3);
    @(posedge clk); #1;
    bus_a.src_noc_ctd_val = 1'b0;
    drive(1'b0, m, 1'b0, c);
    drive(1'b0, e0, 1'b0, c);
    drive(1'b0, e1, 1'b0, c);
    q_a.push_back(exp_flit(r, m, {e0, e1}, 96));

    // msg_len mismatch: one-cycle pulse, all flits still consumed.
    r = {$urandom, $urandom}; r[29:22] = 8'd5;
    m = {$urandom, $urandom}; e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
    drive(1'b0, r, 1'b0, c);
    @(negedge clk);
    chk(bus_a.hdr_len_err == 1'b1, "a_len_err_pulse", 512'(bus_a.hdr_len_err), 512'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk(bus_a.hdr_len_err == 1'b0, "a_len_err_one_cycle", 512'(bus_a.hdr_len_err), '0);
    @(posedge clk); #1;
    drive(1'b0, m, 1'b0, c);
    drive(1'b0, e0, 1'b0, c);
    drive(1'b0, e1, 1'b0, c);
    q_a.push_back(exp_flit(r, m, {e0, e1}, 96));
    err_exp_a++;
    drain();

    // Random bubbles and backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) send_rand(1'b0, 1'b1);
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();

    // Reset mid-message.
    r = {$urandom, $urandom}; r[29:22] = 8'd3;
    drive(1'b0, r, 1'b0, c);
    drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, c);
    rst_n = 1'b0;
    @(negedge clk);
    chk(bus_a.noc_ctd_src_rdy == 1'b0, "a_mid_rst_src_rdy", 512'(bus_a.noc_ctd_src_rdy), '0);
    chk(bus_a.noc_ctd_dst_data === '0, "a_mid_rst_data", bus_a.noc_ctd_dst_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r = {$urandom, $urandom}; r[29:22] = 8'd3;
    send_msg(1'b0, r, 64'h0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, f, l);
    drain();

    // Single extra flit, no padding.
    r = {$urandom, $urandom}; r[29:22] = 8'd2;
    e0 = {$urandom, $urandom};
    send_msg(1'b1, r, {$urandom, $urandom}, e0, 64'h0, 1'b0, f, l);
    chk(l - f == 2, "b_input_cycles", 512'(l - f), 512'd2);
    chk(bus_b.noc_ctd_dst_data[319 -: 64] == e0, "b_extra_field",
        512'(bus_b.noc_ctd_dst_data[319 -: 64]), 512'(e0));
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int i = 0; i < 30; i++) send_rand(1'b1, 1'b1);
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();

    chk(q_a.size() == 0, "a_drain", 512'(q_a.size()), '0);
    chk(q_b.size() == 0, "b_drain", 512'(q_b.size()), '0);
    chk(err_seen_a == err_exp_a, "a_len_err_count", 512'(err_seen_a), 512'(err_exp_a));
    chk(err_seen_b == err_exp_b, "b_len_err_count", 512'(err_seen_b), 512'(err_exp_b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
